// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register-access master.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_halfperiod_tick.sv
// SCLK half-period timebase: tick marks the last clk cycle of each CLK_DIV window.
// restart makes the following cycle the first of a fresh window.
module spi_halfperiod_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 register-access master: serialises {rw, addr, wdata} MSB-first and
// returns the last DATA_W bits sampled from sdi. All timing is clock-enable based.
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int  CLK_DIV = 4,
  parameter int  ADDR_W  = 7,
  parameter int  DATA_W  = 16,
  parameter int  N_CS    = 1,
  localparam int CS_W    = (N_CS > 1) ? $clog2(N_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [CS_W-1:0]   cmd_cs,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              sclk,
  output logic              sdo,
  input  logic              sdi,
  output logic [N_CS-1:0]   csb
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int EDGE_W  = $clog2(2 * FRAME_W + 1);

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [CS_W-1:0]     cs_q, cs_d;
  logic                err_q, err_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic                sclk_q, sclk_d;
  logic [N_CS-1:0]     csb_q, csb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                tick;
  logic                restart;

  // Command handshake: a command transfers on a clk edge with cmd_valid && cmd_ready.
  // cmd_ready is high only in IDLE; cmd_* are sampled on that edge and nowhere else.
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign sclk      = sclk_q;
  assign sdo       = tx_q[FRAME_W-1];
  assign csb       = csb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign restart = (state_d != state_q);

  spi_halfperiod_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cs_d        = cs_q;
    err_d       = err_q;
    edge_d      = edge_q;
    sclk_d      = sclk_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          tx_d    = {cmd_rw, cmd_addr, cmd_wdata};
          cs_d    = cmd_cs;
          err_d   = (int'(cmd_cs) >= N_CS);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          edge_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // sclk low means this tick is a rising edge: sample; otherwise falling: advance sdo.
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          if (!sclk_q) begin
            rx_d = {rx_q[DATA_W-2:0], sdi};
          end else begin
            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
            if (edge_q == EDGE_W'(2 * FRAME_W - 1)) state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rx_q;
          rsp_err_d   = err_q;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Out-of-range indices never match, so an erroneous command leaves every csb high.
    csb_d = '1;
    if (state_d == ST_SETUP || state_d == ST_SHIFT || state_d == ST_HOLD) begin
      for (int i = 0; i < N_CS; i++) begin
        if (int'(cs_d) == i) csb_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      cs_q        <= '0;
      err_q       <= 1'b0;
      edge_q      <= '0;
      sclk_q      <= 1'b0;
      csb_q       <= '1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cs_q        <= cs_d;
      err_q       <= err_d;
      edge_q      <= edge_d;
      sclk_q      <= sclk_d;
      csb_q       <= csb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master: default-width instance with 3 chip selects
// plus a CLK_DIV=2, ADDR_W=15, DATA_W=8 instance.
module tb_spi_reg_master;
  import spi_reg_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int LAT     = 200;
  localparam int LAT_B   = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance A: CLK_DIV=4, ADDR_W=7, DATA_W=16, N_CS=3
  logic        cmd_valid_a, cmd_ready_a, cmd_rw_a;
  logic [6:0]  cmd_addr_a;
  logic [15:0] cmd_wdata_a;
  logic [1:0]  cmd_cs_a;
  logic        rsp_valid_a, rsp_err_a, busy_a, sclk_a, sdo_a, sdi_a;
  logic [15:0] rsp_rdata_a;
  logic [2:0]  csb_a;

  // instance B: CLK_DIV=2, ADDR_W=15, DATA_W=8, N_CS=1
  logic        cmd_valid_b, cmd_ready_b, cmd_rw_b;
  logic [14:0] cmd_addr_b;
  logic [7:0]  cmd_wdata_b;
  logic [0:0]  cmd_cs_b;
  logic        rsp_valid_b, rsp_err_b, busy_b, sclk_b, sdo_b, sdi_b;
  logic [7:0]  rsp_rdata_b;
  logic [0:0]  csb_b;

  spi_reg_master #(.CLK_DIV(4), .ADDR_W(7), .DATA_W(16), .N_CS(3)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_rw(cmd_rw_a), .cmd_addr(cmd_addr_a), .cmd_wdata(cmd_wdata_a), .cmd_cs(cmd_cs_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .busy(busy_a),
    .sclk(sclk_a), .sdo(sdo_a), .sdi(sdi_a), .csb(csb_a)
  );

  spi_reg_master #(.CLK_DIV(2), .ADDR_W(15), .DATA_W(8), .N_CS(1)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_rw(cmd_rw_b), .cmd_addr(cmd_addr_b), .cmd_wdata(cmd_wdata_b), .cmd_cs(cmd_cs_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .busy(busy_b),
    .sclk(sclk_b), .sdo(sdo_b), .sdi(sdi_b), .csb(csb_b)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  cs;
    logic [23:0] sdi_frame;
    logic [23:0] exp_sdo;
    logic [15:0] exp_rdata;
    logic        exp_err;
    logic [2:0]  exp_csb_low;
    int          exp_low_cycles;
  } vec_t;

  vec_t vecs[4];

  // ---------------- driver tasks ----------------
  task automatic wait_ready_a();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready_a", 32'(cmd_ready_a), 32'd1);
  endtask

  task automatic drive_cmd_a(input logic rw, input logic [6:0] addr,
                             input logic [15:0] wdata, input logic [1:0] cs);
    cmd_valid_a = 1'b1;
    cmd_rw_a    = rw;
    cmd_addr_a  = addr;
    cmd_wdata_a = wdata;
    cmd_cs_a    = cs;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          rises = 0;
    int          low_cyc = 0;
    int          lat = -1;
    int          gap = 0;
    int          extra_pulses = 0;
    logic        prev_sclk = 1'b0;
    logic        csb_ok = 1'b1;
    logic [23:0] sdo_bits = '0;
    logic [15:0] got_rdata = '0;
    logic        got_err = 1'b0;
    logic [15:0] exp_rd;

    wait_ready_a();
    drive_cmd_a(v.rw, v.addr, v.wdata, v.cs);
    sdi_a = v.sdi_frame[23];
    exp_q.push_back(v.exp_rdata);
    @(posedge clk);
    for (int cyc = 0; cyc < LAT + 50; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        cmd_valid_a = 1'b0;
        cmd_addr_a  = 7'($urandom_range(0, 127));
        cmd_wdata_a = 16'($urandom_range(0, 65535));
        check($sformatf("v%0d_busy", idx), 32'(busy_a), 32'd1);
      end
      if (csb_a != 3'b111) low_cyc++;
      if (csb_a != 3'b111 && csb_a != v.exp_csb_low) csb_ok = 1'b0;
      if (sclk_a && !prev_sclk) begin
        sdo_bits = {sdo_bits[22:0], sdo_a};
        rises++;
        sdi_a = (rises < 24) ? v.sdi_frame[23 - rises] : 1'b0;
      end
      prev_sclk = sclk_a;
      if (rsp_valid_a) begin
        lat       = cyc;
        got_rdata = rsp_rdata_a;
        got_err   = rsp_err_a;
        break;
      end
    end

    check($sformatf("v%0d_latency", idx), lat, LAT);
    check($sformatf("v%0d_rises", idx), rises, 24);
    check($sformatf("v%0d_sdo_frame", idx), 32'(sdo_bits), 32'(v.exp_sdo));
    check($sformatf("v%0d_csb_low_cycles", idx), low_cyc, v.exp_low_cycles);
    check($sformatf("v%0d_csb_select", idx), 32'(csb_ok), 32'd1);
    check($sformatf("v%0d_err", idx), 32'(got_err), 32'(v.exp_err));
    exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check($sformatf("v%0d_rdata", idx), 32'(got_rdata), 32'(exp_rd));

    // GAP: csb stays high, no repeated pulse, rdata held, cmd_ready after CLK_DIV cycles.
    while (gap < 20) begin
      @(negedge clk);
      gap++;
      if (rsp_valid_a) extra_pulses++;
      if (cmd_ready_a) break;
    end
    check($sformatf("v%0d_ready_gap", idx), gap, CLK_DIV);
    check($sformatf("v%0d_single_pulse", idx), extra_pulses, 0);
    check($sformatf("v%0d_rdata_held", idx), 32'(rsp_rdata_a), 32'(exp_rd));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{RW_WRITE, 7'h2A, 16'hBEEF, 2'd0, 24'h000000, 24'h2ABEEF, 16'h0000, 1'b0, 3'b110, 200};
    vecs[1] = '{RW_READ,  7'h05, 16'h0000, 2'd0, 24'hFF1234, 24'h850000, 16'h1234, 1'b0, 3'b110, 200};
    vecs[2] = '{RW_READ,  7'h7F, 16'hFFFF, 2'd2, 24'h00A5C3, 24'hFFFFFF, 16'hA5C3, 1'b0, 3'b011, 200};
    vecs[3] = '{RW_WRITE, 7'h11, 16'h0F0F, 2'd3, 24'h123456, 24'h110F0F, 16'h3456, 1'b1, 3'b111, 0};

    reset = 1'b1;
    cmd_valid_a = 1'b0; cmd_rw_a = 1'b0; cmd_addr_a = '0; cmd_wdata_a = '0; cmd_cs_a = '0; sdi_a = 1'b0;
    cmd_valid_b = 1'b0; cmd_rw_b = 1'b0; cmd_addr_b = '0; cmd_wdata_b = '0; cmd_cs_b = '0; sdi_b = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_csb", 32'(csb_a), 32'h7);
    check("rst_sclk", 32'(sclk_a), 32'd0);
    check("rst_sdo", 32'(sdo_a), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata_a), 32'd0);
    check("rst_rsp_err", 32'(rsp_err_a), 32'd0);
    check("rst_b_csb", 32'(csb_b), 32'd1);
    check("rst_b_ready", 32'(cmd_ready_b), 32'd1);
    reset = 1'b0;

    // table-driven single transactions (write, read, other cs, invalid cs)
    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // reset in SHIFT after 10 sclk edges aborts without a response
    begin
      int   edges = 0;
      int   pulses = 0;
      logic prev = 1'b0;
      wait_ready_a();
      drive_cmd_a(RW_READ, 7'h15, 16'h0000, 2'd1);
      sdi_a = 1'b1;
      @(posedge clk);
      for (int cyc = 0; cyc < LAT; cyc++) begin
        @(negedge clk);
        if (cyc == 0) cmd_valid_a = 1'b0;
        if (sclk_a != prev) edges++;
        prev = sclk_a;
        if (edges == 10) break;
      end
      check("abort_edges_seen", edges, 10);
      reset = 1'b1;
      @(negedge clk);
      check("abort_csb", 32'(csb_a), 32'h7);
      check("abort_sclk", 32'(sclk_a), 32'd0);
      check("abort_sdo", 32'(sdo_a), 32'd0);
      check("abort_cmd_ready", 32'(cmd_ready_a), 32'd1);
      check("abort_busy", 32'(busy_a), 32'd0);
      check("abort_rsp_rdata", 32'(rsp_rdata_a), 32'd0);
      reset = 1'b0;
      sdi_a = 1'b0;
      for (int cyc = 0; cyc < LAT + 50; cyc++) begin
        @(negedge clk);
        if (rsp_valid_a) pulses++;
      end
      check("abort_no_rsp", pulses, 0);
    end

    // cmd_valid held high for exactly three back-to-back commands
    begin
      int   accepts = 0;
      int   rsps = 0;
      int   gap_run = 0;
      int   min_gap = 1000;
      logic seen_low = 1'b0;
      logic drop = 1'b0;
      logic [15:0] exp_rd;
      wait_ready_a();
      drive_cmd_a(RW_WRITE, 7'h33, 16'h1357, 2'd1);
      sdi_a = 1'b0;
      for (int cyc = 0; cyc < 900; cyc++) begin
        if (cmd_valid_a && cmd_ready_a) begin
          accepts++;
          exp_q.push_back(16'h0000);
          if (accepts == 3) drop = 1'b1;
        end
        @(negedge clk);
        if (drop) cmd_valid_a = 1'b0;
        if (csb_a != 3'b111) begin
          if (seen_low && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
          gap_run  = 0;
          seen_low = 1'b1;
        end else if (seen_low) begin
          gap_run++;
        end
        if (rsp_valid_a) begin
          rsps++;
          exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
          check($sformatf("b2b_rdata%0d", rsps), 32'(rsp_rdata_a), 32'(exp_rd));
        end
      end
      check("b2b_accepts", accepts, 3);
      check("b2b_rsps", rsps, 3);
      check("b2b_csb_gap_ok", 32'(min_gap >= CLK_DIV && min_gap < 1000), 32'd1);
      check("b2b_queue_empty", exp_q.size(), 0);
    end

    // instance B: CLK_DIV=2, 15-bit address, 8-bit data, read
    begin
      int          rises = 0;
      int          low_cyc = 0;
      int          lat = -1;
      int          last_rise = -1;
      logic        period_ok = 1'b1;
      logic        prev = 1'b0;
      logic [23:0] sdo_bits = '0;
      logic [23:0] sdi_frame = 24'h5A00C3;
      logic [7:0]  got_rdata = '0;
      logic        got_err = 1'b1;
      @(negedge clk);
      cmd_valid_b = 1'b1;
      cmd_rw_b    = RW_READ;
      cmd_addr_b  = 15'h1234;
      cmd_wdata_b = 8'hA5;
      cmd_cs_b    = 1'b0;
      sdi_b       = sdi_frame[23];
      check("b_ready_before", 32'(cmd_ready_b), 32'd1);
      @(posedge clk);
      for (int cyc = 0; cyc < LAT_B + 30; cyc++) begin
        @(negedge clk);
        if (cyc == 0) cmd_valid_b = 1'b0;
        if (csb_b == 1'b0) low_cyc++;
        if (sclk_b && !prev) begin
          if (last_rise >= 0 && cyc - last_rise != 4) period_ok = 1'b0;
          last_rise = cyc;
          sdo_bits  = {sdo_bits[22:0], sdo_b};
          rises++;
          sdi_b = (rises < 24) ? sdi_frame[23 - rises] : 1'b0;
        end
        prev = sclk_b;
        if (rsp_valid_b) begin
          lat       = cyc;
          got_rdata = rsp_rdata_b;
          got_err   = rsp_err_b;
          break;
        end
      end
      check("b_latency", lat, LAT_B);
      check("b_rises", rises, 24);
      check("b_sclk_period", 32'(period_ok), 32'd1);
      check("b_sdo_frame", 32'(sdo_bits), 32'h9234A5);
      check("b_csb_low_cycles", low_cyc, LAT_B);
      check("b_rdata", 32'(got_rdata), 32'hC3);
      check("b_err", 32'(got_err), 32'd0);
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
